axi_burst_master: RTL and testbench
===================================

# axi_burst_master

Parametrised AXI burst master engine for the verification/RTL AXI subsystem. Accepts one command at a time from a local command port and executes a full write (AW, W, B) or read (AR, R) burst. Supports FIXED, INCR and WRAP bursts, byte strobes, per-beat address tracking and a handshake timeout monitor. Sits between a local controller or sequencer and an AXI slave or interconnect port.

## Interface
- DATA_WIDTH, 32: W/R data width in bits; power of two, 8..1024.
- ADDR_WIDTH, 32: address width in bits.
- TIMEOUT, 16: cycles a VALID may wait for READY before `timeout_err` is set; at least 1.

- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  4  beats minus 1.
- cmd_size  in  3  log2 bytes per beat.
- cmd_burst  in  2  0 FIXED, 1 INCR, 2 WRAP.
- wd_valid / wd_ready  in / out  1 / 1  local write-data stream.
- wd_data  in  DATA_WIDTH  write data for the current beat.
- wd_strb  in  DATA_WIDTH/8  byte strobes for the current beat.
- rd_valid / rd_ready  out / in  1 / 1  local read-data stream.
- rd_data  out  DATA_WIDTH  read data.
- rd_addr  out  ADDR_WIDTH  address of the current read beat.
- rd_last  out  1  last read beat.
- done  out  1  one-cycle pulse when a command completes.
- resp  out  2  BRESP, or the worst RRESP across the burst; valid with `done`.
- cmd_err  out  1  one-cycle pulse when an illegal command is rejected.
- timeout_err, last_err  out  1, 1  sticky error flags; cleared only by reset.
- AXI master ports AW*, W*, B*, AR*, R*:
  - AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID/AWREADY
  - WDATA/WSTRB/WLAST/WVALID/WREADY
  - BRESP/BVALID/BREADY
  - ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID/ARREADY
  - RDATA/RRESP/RLAST/RVALID/RREADY
  - Widths: LEN 4, SIZE 3, BURST 2, RESP 2.

## Operation
- States:
  - IDLE: `cmd_ready`=1. Command accepted moves to AW or AR; illegal command pulses `cmd_err` and stays in IDLE.
  - AW: AWVALID=1; on AWREADY go to W.
  - W: beats via wd pass-through; on the handshake with WLAST=1 go to B.
  - B: BREADY=1; on BVALID go to IDLE, `done` pulses.
  - AR: ARVALID=1; on ARREADY go to R.
  - R: R pass-through; on the beat-(len) handshake go to IDLE, `done` pulses.
- Illegal commands:
  - `cmd_size` > log2(DATA_WIDTH/8);
  - `cmd_burst`=3;
  - WRAP with `cmd_len` not 1, 3, 7 or 15.
- Addr/len/size/burst are registered at acceptance and held stable while AxVALID is high.
- W pass-through:
  - WVALID = wd_valid and `wd_ready` = WREADY, both only in W.
  - WDATA/WSTRB = wd_data/wd_strb.
  - WLAST=1 when beat counter == len.
- R pass-through:
  - RREADY = rd_ready in R.
  - rd_valid = RVALID in R; rd_data = RDATA.
  - rd_last = beat counter == len.
  - If RLAST differs from the internal last, set `last_err`; the engine still ends on the internal count.
- Beat address after each handshake:
  - FIXED: unchanged.
  - INCR: addr + 2^size, modulo 2^ADDR_WIDTH.
  - WRAP: add 2^size within a container of (len+1)·2^size bytes aligned down from the start address.
- `resp` during the burst:
  - Write: `resp` = BRESP.
  - Read: `resp` = max RRESP seen (SLVERR/DECERR dominate OKAY).
- Timeout: a per-state counter resets on entry and on each handshake; reaching TIMEOUT sets `timeout_err`. VALID is never dropped; the engine keeps waiting.

## Timing
- Reset values:
  - state IDLE;
  - all VALID/READY outputs 0, except `cmd_ready`, which is 1 once out of reset;
  - AW/AR fields 0, WLAST 0, `rd_last` 0;
  - `done`, `cmd_err`, `timeout_err`, `last_err` 0; `resp` 0.
- Reset mid-burst: abandon the burst, return to IDLE next cycle, drop all VALIDs.
- Cycle after acceptance: AxVALID=1. Minimum AW to B is len+3 cycles with zero slave wait states.
- Back-to-back commands: `cmd_ready` is high in the same cycle `done` pulses, so there are no dead cycles.
- W beats are combinational pass-through: no bubbles, no added latency.

## Structure
- Package `axi_burst_pkg`:
  - burst, resp and state enums;
  - LEN/SIZE/RESP width constants;
  - function `legal_cmd()`.
- Sub-module `axi_beat_addr`: combinational next-address calculator for FIXED/INCR/WRAP. Shared by write tracking and `rd_addr`.

## Test plan
- Write INCR, addr 0x100, len 3, size 2, AWREADY/WREADY always 1, BRESP OKAY → WDATA beats 1..4, WLAST on beat 4 only, `done` after 6 cycles, `resp`=0.
- Read WRAP, addr 0x38, len 3, size 2 → `rd_addr` 0x38, 0x3C, 0x30, 0x34; `rd_last` on the 4th beat.
- Read FIXED, len 7, RRESP=2 on beat 5 → `rd_addr` constant; `resp`=2 with `done`.
- AWREADY held low 20 cycles (TIMEOUT=16) → `timeout_err`=1 at wait cycle 16, AWVALID stays 1, burst then completes normally.
- Illegal commands: WRAP len 2, and size 3 with DATA_WIDTH 32 → `cmd_err` pulse, no AW/AR activity. RLAST early on read beat 2 of 4 → `last_err`=1, all 4 beats delivered.
- ARESET asserted in W beat 2 → next cycle IDLE, WVALID=0, `cmd_ready`=1, no `done`.

Source files
------------

// File: rtl/axi_burst_pkg.sv
// Shared types, widths and command legality check for the AXI burst master.
package axi_burst_pkg;

  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_AW   = 3'd1;
  localparam state_t ST_W    = 3'd2;
  localparam state_t ST_B    = 3'd3;
  localparam state_t ST_AR   = 3'd4;
  localparam state_t ST_R    = 3'd5;

  function automatic logic legal_cmd(input logic [SIZE_W-1:0]  size,
                                     input logic [BURST_W-1:0] burst,
                                     input logic [LEN_W-1:0]   len,
                                     input logic [SIZE_W-1:0]  max_size);
    logic ok;
    ok = (size <= max_size) && (burst != BURST_RSVD);
    if (burst == BURST_WRAP)
      ok = ok && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
    return ok;
  endfunction

endpackage

// File: rtl/axi_burst_master_beat_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_beat_addr
  import axi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LEN_W-1:0]      i_len,
  input  logic [SIZE_W-1:0]     i_size,
  input  logic [BURST_W-1:0]    i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;

  assign w_incr = i_addr + (ADDR_WIDTH'(1) << i_size);
  // Wrap container is (len+1) beats; it is aligned, so the upper bits of any
  // address inside it identify the container.
  assign w_wrap_mask = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    o_next_addr = i_addr;
    case (i_burst)
      BURST_INCR: o_next_addr = w_incr;
      BURST_WRAP: o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default:    o_next_addr = i_addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_master.sv
// Single-command AXI burst engine: one write (AW/W/B) or read (AR/R) burst per command.
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic [SIZE_W-1:0]       cmd_size,
  input  logic [BURST_W-1:0]      cmd_burst,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_last,
  output logic                    done,
  output logic [RESP_W-1:0]       resp,
  output logic                    cmd_err,
  output logic                    timeout_err,
  output logic                    last_err,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [LEN_W-1:0]        AWLEN,
  output logic [SIZE_W-1:0]       AWSIZE,
  output logic [BURST_W-1:0]      AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [RESP_W-1:0]       BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [LEN_W-1:0]        ARLEN,
  output logic [SIZE_W-1:0]       ARSIZE,
  output logic [BURST_W-1:0]      ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [RESP_W-1:0]       RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'($clog2(DATA_WIDTH/8));
  localparam int                TCNT_W   = $clog2(TIMEOUT + 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_cnt;
  logic [SIZE_W-1:0]     r_size;
  logic [BURST_W-1:0]    r_burst;
  logic [RESP_W-1:0]     r_resp;
  logic [TCNT_W-1:0]     r_tcnt;
  logic                  r_done;
  logic                  r_cmd_err;
  logic                  r_timeout_err;
  logic                  r_last_err;

  logic                  w_cmd_hs, w_legal, w_accept;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_any_hs;
  logic                  w_is_last, w_stall;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [RESP_W-1:0]     w_rresp_max;

  axi_beat_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_beat_addr (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign AWVALID   = (r_state == ST_AW);
  assign ARVALID   = (r_state == ST_AR);
  assign BREADY    = (r_state == ST_B);
  assign WVALID    = (r_state == ST_W) && wd_valid;
  assign wd_ready  = (r_state == ST_W) && WREADY;
  assign RREADY    = (r_state == ST_R) && rd_ready;
  assign rd_valid  = (r_state == ST_R) && RVALID;

  assign w_is_last = (r_cnt == r_len);
  assign WLAST     = (r_state == ST_W) && w_is_last;
  assign rd_last   = (r_state == ST_R) && w_is_last;

  assign {AWADDR, AWLEN, AWSIZE, AWBURST} = {r_addr, r_len, r_size, r_burst};
  assign {ARADDR, ARLEN, ARSIZE, ARBURST} = {r_addr, r_len, r_size, r_burst};
  assign WDATA   = wd_data;
  assign WSTRB   = wd_strb;
  assign rd_data = RDATA;
  assign rd_addr = r_addr;

  assign done        = r_done;
  assign resp        = r_resp;
  assign cmd_err     = r_cmd_err;
  assign timeout_err = r_timeout_err;
  assign last_err    = r_last_err;

  assign w_cmd_hs    = cmd_valid && cmd_ready;
  assign w_legal     = legal_cmd(cmd_size, cmd_burst, cmd_len, MAX_SIZE);
  assign w_accept    = w_cmd_hs && w_legal;
  assign w_aw_hs     = AWVALID && AWREADY;
  assign w_w_hs      = WVALID && WREADY;
  assign w_b_hs      = BREADY && BVALID;
  assign w_ar_hs     = ARVALID && ARREADY;
  assign w_r_hs      = RVALID && RREADY;
  assign w_any_hs    = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;
  assign w_rresp_max = (RRESP > r_resp) ? RRESP : r_resp;

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = cmd_write ? ST_AW : ST_AR;
      ST_AW: begin
        w_stall = !AWREADY;
        if (w_aw_hs) w_state_next = ST_W;
      end
      ST_W: begin
        w_stall = wd_valid && !WREADY;
        if (w_w_hs && w_is_last) w_state_next = ST_B;
      end
      ST_B: begin
        w_stall = !BVALID;
        if (w_b_hs) w_state_next = ST_IDLE;
      end
      ST_AR: begin
        w_stall = !ARREADY;
        if (w_ar_hs) w_state_next = ST_R;
      end
      ST_R: begin
        w_stall = rd_ready && !RVALID;
        if (w_r_hs && w_is_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_resp        <= '0;
      r_tcnt        <= '0;
      r_done        <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_last_err    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_done    <= w_b_hs || (w_r_hs && w_is_last);
      r_cmd_err <= w_cmd_hs && !w_legal;

      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_len   <= cmd_len;
        r_size  <= cmd_size;
        r_burst <= cmd_burst;
        r_cnt   <= '0;
        r_resp  <= '0;
      end

      if (w_w_hs || w_r_hs) begin
        r_addr <= w_next_addr;
        r_cnt  <= r_cnt + LEN_W'(1);
      end

      if (w_r_hs) begin
        r_resp <= w_rresp_max;
        if (RLAST != w_is_last) r_last_err <= 1'b1;
      end
      if (w_b_hs) r_resp <= BRESP;

      // Wait counter restarts on each new state and each handshake; it
      // saturates, the error is sticky and the engine keeps waiting.
      if (w_state_next != r_state || w_any_hs) begin
        r_tcnt <= '0;
      end else if (w_stall && r_tcnt != TCNT_W'(TIMEOUT)) begin
        r_tcnt <= r_tcnt + TCNT_W'(1);
        if (r_tcnt == TCNT_W'(TIMEOUT - 1)) r_timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: writes, reads, timeout, illegal commands, reset.
module tb_axi_burst_master;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic [3:0]    wd_strb;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          done, cmd_err, timeout_err, last_err;
  logic [1:0]    resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [3:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic [1:0]    AWBURST, ARBURST, BRESP, RRESP;
  logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [3:0]    WSTRB;

  int n_checks = 0;
  int n_errors = 0;

  axi_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_addr(rd_addr),
    .rd_last(rd_last), .done(done), .resp(resp), .cmd_err(cmd_err),
    .timeout_err(timeout_err), .last_err(last_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: rising edge applies inputs, outputs are sampled after the falling edge.
  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [AW-1:0] wrap_addrs [4];

  initial begin
    wrap_addrs[0] = 32'h38; wrap_addrs[1] = 32'h3C;
    wrap_addrs[2] = 32'h30; wrap_addrs[3] = 32'h34;
    ARESET = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    wd_valid = 0; wd_data = '0; wd_strb = '0; rd_ready = 0;
    AWREADY = 0; WREADY = 0; BRESP = '0; BVALID = 0; ARREADY = 0;
    RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
    @(negedge ACLK);
    tick();
    tick();

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rd_valid}, 0);
    check("rst_fields", {AWADDR, AWLEN, AWSIZE, AWBURST, WLAST, rd_last}, 0);
    check("rst_flags", {done, cmd_err, timeout_err, last_err, resp}, 0);
    ARESET = 1'b0;

    // Write INCR 0x100, len 3, size 2, zero wait states
    AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'd0;
    wd_valid = 1; wd_data = 32'd1; wd_strb = 4'hF;
    issue(1'b1, 32'h100, 4'd3, 3'd2, 2'd1);
    check("w_awvalid", AWVALID, 1);
    check("w_aw_fields", {AWADDR, AWLEN, AWSIZE, AWBURST}, {32'h100, 4'd3, 3'd2, 2'd1});
    check("w_wvalid_in_aw", WVALID, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("w_wvalid", {WVALID, wd_ready}, 2'b11);
      check("w_wdata", {WDATA, WSTRB}, {32'(i + 1), 4'hF});
      check("w_wlast", WLAST, (i == 3));
      wd_data = 32'(i + 2);
      tick();
    end
    wd_valid = 0;
    check("w_bready", {BREADY, WVALID, done}, 3'b100);
    tick();
    check("w_done", {done, resp, cmd_ready}, {1'b1, 2'd0, 1'b1});
    tick();
    check("w_done_pulse", done, 0);

    // Read WRAP 0x38, len 3, size 2
    ARREADY = 1; RVALID = 1; rd_ready = 1;
    issue(1'b0, 32'h38, 4'd3, 3'd2, 2'd2);
    check("rw_ar", {ARVALID, ARADDR, ARLEN, ARBURST, AWVALID}, {1'b1, 32'h38, 4'd3, 2'd2, 1'b0});
    tick();
    for (int i = 0; i < 4; i++) begin
      RDATA = 32'hA0 + 32'(i); RLAST = (i == 3); RRESP = 2'd0;
      check("rw_addr", rd_addr, wrap_addrs[i]);
      check("rw_beat", {rd_valid, RREADY, rd_data}, {2'b11, 32'hA0 + 32'(i)});
      check("rw_last", rd_last, (i == 3));
      tick();
    end
    check("rw_done", {done, resp}, {1'b1, 2'd0});

    // Read FIXED 0x200, len 7, SLVERR on beat 5
    issue(1'b0, 32'h200, 4'd7, 3'd2, 2'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      RDATA = 32'(i); RLAST = (i == 7); RRESP = (i == 4) ? 2'd2 : 2'd0;
      check("rf_addr", rd_addr, 32'h200);
      check("rf_last", rd_last, (i == 7));
      check("rf_no_done", done, 0);
      tick();
    end
    RRESP = 2'd0;
    check("rf_done", {done, resp}, {1'b1, 2'd2});
    check("rf_no_errs", {timeout_err, last_err}, 2'b00);

    // AWREADY held low 20 cycles
    AWREADY = 0;
    issue(1'b1, 32'h0, 4'd0, 3'd2, 2'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15) check("to_before", timeout_err, 0);
      if (k == 16) check("to_at16", timeout_err, 1);
    end
    check("to_awvalid_held", AWVALID, 1);
    AWREADY = 1; wd_valid = 1; wd_data = 32'h55;
    tick();
    check("to_w", {WVALID, WLAST, WDATA}, {2'b11, 32'h55});
    tick();
    wd_valid = 0;
    tick();
    check("to_done", {done, resp, timeout_err}, {1'b1, 2'd0, 1'b1});

    // Illegal commands: WRAP len 2, then size 3 on a 32-bit bus
    issue(1'b1, 32'h40, 4'd2, 3'd2, 2'd2);
    check("ill_wrap", {cmd_err, AWVALID, ARVALID, cmd_ready}, 4'b1001);
    tick();
    check("ill_pulse", {cmd_err, AWVALID}, 2'b00);
    issue(1'b0, 32'h40, 4'd0, 3'd3, 2'd1);
    check("ill_size", {cmd_err, AWVALID, ARVALID, cmd_ready}, 4'b1001);
    tick();
    check("ill_pulse2", {cmd_err, ARVALID}, 2'b00);

    // Early RLAST on beat 2 of 4
    check("le_before", last_err, 0);
    issue(1'b0, 32'h80, 4'd3, 3'd2, 2'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      RDATA = 32'(i); RLAST = (i == 1);
      check("le_beat", {rd_valid, rd_addr}, {1'b1, 32'h80 + 32'(4 * i)});
      tick();
    end
    RLAST = 0;
    check("le_done", {done, last_err}, 2'b11);

    // Reset during W beat 2
    wd_valid = 1; wd_data = 32'h11;
    issue(1'b1, 32'h300, 4'd3, 3'd2, 2'd1);
    tick();
    tick();
    check("rs_in_w", {WVALID, WLAST}, 2'b10);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    check("rs_idle", {WVALID, AWVALID, cmd_ready, done}, 4'b0010);
    check("rs_flags", {timeout_err, last_err}, 2'b00);
    tick();
    check("rs_no_done", done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
